// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding and
// weight-set sizing helper.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_START,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Number of weight words in one full layer load.
    function automatic int unsigned total_words(input int unsigned inputs,
                                                input int unsigned neurons);
        return inputs * neurons;
    endfunction

endpackage

// File: rtl/layer_sequencer_addr.sv
// Nested weight/neuron address counter for neuron-major weight streaming.
// Flags the final word of the set and wraps both counters after it.
module weight_addr_counter #(
    parameter int INPUTS  = 400,
    parameter int NEURONS = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       advance,
    output logic [$clog2(INPUTS)-1:0]  weight_idx,
    output logic [$clog2(NEURONS)-1:0] neuron_idx,
    output logic                       last
);

    localparam int WW = $clog2(INPUTS);
    localparam int NW = $clog2(NEURONS);
    localparam logic [WW-1:0] W_LAST = WW'(INPUTS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(NEURONS - 1);

    logic w_wrap;

    assign w_wrap = (weight_idx == W_LAST);
    assign last   = w_wrap && (neuron_idx == N_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_idx <= '0;
            neuron_idx <= '0;
        end else if (clear) begin
            weight_idx <= '0;
            neuron_idx <= '0;
        end else if (advance) begin
            if (w_wrap) begin
                weight_idx <= '0;
                neuron_idx <= last ? '0 : neuron_idx + NW'(1);
            end else begin
                weight_idx <= weight_idx + WW'(1);
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Sequencer between the host weight stream and one fully-connected layer:
// loads weights neuron-major, then pulses layer start and waits for done.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int INPUTS  = 400,
    parameter int NEURONS = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_req,
    input  logic                       run_after,
    input  logic                       run_req,
    input  logic                       abort,
    input  logic                       wvalid,
    input  logic [63:0]                wdata,
    output logic                       wready,
    output logic                       write_weight,
    output logic [$clog2(NEURONS)-1:0] neuron_sel,
    output logic [$clog2(INPUTS)-1:0]  weight_sel,
    output logic [63:0]                weight_bus,
    output logic                       layer_start,
    input  logic                       layer_done,
    output logic                       busy,
    output logic                       load_done,
    output logic                       run_done
);

    state_t                       state;
    state_t                       next_state;
    logic                         auto_run;
    logic                         accept;
    logic                         last_word;
    logic                         cnt_clear;
    logic [$clog2(INPUTS)-1:0]    weight_idx;
    logic [$clog2(NEURONS)-1:0]   neuron_idx;

    // abort drops wready in its own cycle so no word is taken while leaving.
    assign wready    = (state == ST_LOAD) && !abort;
    assign accept    = wvalid && wready;
    assign cnt_clear = abort || ((state == ST_IDLE) && load_req);

    weight_addr_counter #(
        .INPUTS  (INPUTS),
        .NEURONS (NEURONS)
    ) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .advance    (accept),
        .weight_idx (weight_idx),
        .neuron_idx (neuron_idx),
        .last       (last_word)
    );

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (load_req)     next_state = ST_LOAD;
                else if (run_req) next_state = ST_START;
            end
            ST_LOAD:  if (accept && last_word) next_state = ST_FLUSH;
            ST_FLUSH: next_state = auto_run ? ST_START : ST_IDLE;
            ST_START: next_state = ST_WAIT;
            ST_WAIT:  if (layer_done) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (abort) next_state = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            auto_run <= 1'b0;
        end else begin
            state <= next_state;
            if (abort)
                auto_run <= 1'b0;
            else if ((state == ST_IDLE) && load_req)
                auto_run <= run_after;
        end
    end

    // Write port lags acceptance by one cycle; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_weight <= 1'b0;
            neuron_sel   <= '0;
            weight_sel   <= '0;
            weight_bus   <= '0;
        end else begin
            write_weight <= accept;
            if (accept) begin
                neuron_sel <= neuron_idx;
                weight_sel <= weight_idx;
                weight_bus <= wdata;
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign load_done   = (state == ST_FLUSH);
    assign layer_start = (state == ST_START);
    assign run_done    = (state == ST_DONE);

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a 3-neuron x 4-input layer:
// full loads, stalled loads, auto-run, standalone run, abort and reset.
module tb_layer_sequencer;

    localparam int INPUTS  = 4;
    localparam int NEURONS = 3;

    logic        clk;
    logic        rst_n;
    logic        load_req;
    logic        run_after;
    logic        run_req;
    logic        abort;
    logic        wvalid;
    logic [63:0] wdata;
    logic        wready;
    logic        write_weight;
    logic [1:0]  neuron_sel;
    logic [1:0]  weight_sel;
    logic [63:0] weight_bus;
    logic        layer_start;
    logic        layer_done;
    logic        busy;
    logic        load_done;
    logic        run_done;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int wr0;
    int st0;
    int rd0;

    layer_sequencer #(
        .INPUTS  (INPUTS),
        .NEURONS (NEURONS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_req     (load_req),
        .run_after    (run_after),
        .run_req      (run_req),
        .abort        (abort),
        .wvalid       (wvalid),
        .wdata        (wdata),
        .wready       (wready),
        .write_weight (write_weight),
        .neuron_sel   (neuron_sel),
        .weight_sel   (weight_sel),
        .weight_bus   (weight_bus),
        .layer_start  (layer_start),
        .layer_done   (layer_done),
        .busy         (busy),
        .load_done    (load_done),
        .run_done     (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_weight) wr_cnt++;
            if (layer_start)  start_cnt++;
            if (run_done)     done_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_write(input string tag, input int n, input int w, input int bus);
        check({tag, "_we"},  write_weight, 1);
        check({tag, "_nsel"}, neuron_sel, n);
        check({tag, "_wsel"}, weight_sel, w);
        check({tag, "_bus"},  weight_bus, bus);
    endtask

    initial begin
        rst_n = 1'b0; load_req = 1'b0; run_after = 1'b0; run_req = 1'b0;
        abort = 1'b0; wvalid = 1'b0; wdata = '0; layer_done = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_wready", wready, 0);
        check("rst_we", write_weight, 0);
        check("rst_start", layer_start, 0);
        check("rst_load_done", load_done, 0);
        check("rst_run_done", run_done, 0);
        check("rst_bus", weight_bus, 0);
        #11 rst_n = 1'b1;
        step();

        // Full load, wvalid held high, no auto-run.
        wr0 = wr_cnt; st0 = start_cnt;
        load_req = 1'b1; run_after = 1'b0;
        step();
        load_req = 1'b0; wvalid = 1'b1; #1;
        check("t1_wready", wready, 1);
        check("t1_busy", busy, 1);
        for (int k = 0; k < 12; k++) begin
            wdata = 64'(k);
            step();
            check_write("t1", k / 4, k % 4, k);
            check("t1_load_done", load_done, (k == 11) ? 1 : 0);
        end
        wvalid = 1'b0;
        check("t1_flush_wready", wready, 0);
        step();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_we", write_weight, 0);
        check("t1_idle_start", layer_start, 0);
        check("t1_writes", wr_cnt - wr0, 12);
        check("t1_no_start", start_cnt - st0, 0);

        // Same load with wvalid toggling: writes only after valid cycles.
        wr0 = wr_cnt;
        load_req = 1'b1;
        step();
        load_req = 1'b0;
        for (int i = 0; i < 24; i++) begin
            wvalid = (i % 2 == 0);
            wdata  = 64'(100 + i / 2);
            step();
            if (i % 2 == 0) begin
                check_write("t2", (i / 2) / 4, (i / 2) % 4, 100 + i / 2);
                check("t2_load_done", load_done, (i == 22) ? 1 : 0);
            end else begin
                check("t2_stall_we", write_weight, 0);
            end
        end
        wvalid = 1'b0;
        check("t2_writes", wr_cnt - wr0, 12);
        check("t2_busy", busy, 0);

        // Load with auto-run, layer_done modelled 7 cycles after start.
        st0 = start_cnt; rd0 = done_cnt;
        load_req = 1'b1; run_after = 1'b1;
        step();
        load_req = 1'b0; run_after = 1'b0; wvalid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            wdata = 64'(200 + k);
            step();
        end
        wvalid = 1'b0;
        check("t3_load_done", load_done, 1);
        check("t3_last_bus", weight_bus, 211);
        check("t3_no_early_start", layer_start, 0);
        step();
        check("t3_start", layer_start, 1);
        check("t3_load_done_clr", load_done, 0);
        for (int j = 1; j < 7; j++) begin
            step();
            check("t3_wait_start", layer_start, 0);
            check("t3_wait_run_done", run_done, 0);
        end
        step();
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        check("t3_run_done", run_done, 1);
        check("t3_busy_done", busy, 1);
        step();
        check("t3_run_done_clr", run_done, 0);
        check("t3_busy_idle", busy, 0);
        check("t3_starts", start_cnt - st0, 1);
        check("t3_run_dones", done_cnt - rd0, 1);

        // Standalone run; layer_done with layer_start ignored; run_req in WAIT ignored.
        wr0 = wr_cnt; st0 = start_cnt; rd0 = done_cnt;
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("t4_start", layer_start, 1);
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        check("t4_start_clr", layer_start, 0);
        check("t4_early_done_ignored", run_done, 0);
        check("t4_wait_busy", busy, 1);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        check("t4_rerun_ignored", layer_start, 0);
        check("t4_still_wait", run_done, 0);
        layer_done = 1'b1;
        step();
        layer_done = 1'b0;
        check("t4_run_done", run_done, 1);
        step();
        check("t4_busy_idle", busy, 0);
        check("t4_no_writes", wr_cnt - wr0, 0);
        check("t4_starts", start_cnt - st0, 1);
        check("t4_run_dones", done_cnt - rd0, 1);

        // Abort after 5 accepted words, then a fresh load restarts at 0/0.
        wr0 = wr_cnt;
        load_req = 1'b1;
        step();
        load_req = 1'b0; wvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wdata = 64'(300 + k);
            step();
            check_write("t5", k / 4, k % 4, 300 + k);
        end
        abort = 1'b1; wdata = 64'd999; #1;
        check("t5_abort_wready", wready, 0);
        step();
        abort = 1'b0; wvalid = 1'b0;
        check("t5_abort_we", write_weight, 0);
        check("t5_abort_busy", busy, 0);
        check("t5_hold_nsel", neuron_sel, 1);
        check("t5_hold_wsel", weight_sel, 0);
        check("t5_hold_bus", weight_bus, 304);
        check("t5_writes", wr_cnt - wr0, 5);
        load_req = 1'b1;
        step();
        load_req = 1'b0; wvalid = 1'b1; wdata = 64'd400;
        step();
        wvalid = 1'b0;
        check_write("t5_restart", 0, 0, 400);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort2_busy", busy, 0);

        // Asynchronous reset while waiting for the layer.
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        check("t6_wait_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_start", layer_start, 0);
        check("t6_rst_we", write_weight, 0);
        check("t6_rst_bus", weight_bus, 0);
        check("t6_rst_nsel", neuron_sel, 0);
        check("t6_rst_wready", wready, 0);
        #3 rst_n = 1'b1;
        step();
        check("t6_post_busy", busy, 0);
        check("t6_post_start", layer_start, 0);
        check("t6_post_run_done", run_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Controller sitting between the accelerator's host/DMA stream and one fully-connected layer instance.
- Streams a layer's weight set into the layer's per-neuron weight write port, in neuron-major order, under a valid/ready handshake.
- Issues the layer's one-cycle start pulse and waits for its done pulse, then reports completion.
- Run can follow a load automatically or be requested standalone; weights are retained between runs.

Parameters:
- INPUTS, 400, weights per neuron (layer fan-in).
- NEURONS, 15, neurons in the driven layer.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  pulse: begin weight load (auto-runs if run_after=1)
- run_after  in  1  sampled with load_req; 1 = start layer once load completes
- run_req  in  1  pulse: start layer using resident weights
- abort  in  1  return to IDLE from any state next cycle
- wvalid  in  1  weight word valid
- wdata  in  64  weight word
- wready  out  1  sequencer accepts word this cycle
- write_weight  out  1  layer weight write strobe
- neuron_sel  out  $clog2(NEURONS)  target neuron
- weight_sel  out  $clog2(INPUTS)  target weight index
- weight_bus  out  64  weight value
- layer_start  out  1  one-cycle start pulse to layer
- layer_done  in  1  layer completion pulse
- busy  out  1  state != IDLE
- load_done  out  1  one-cycle pulse, last weight written
- run_done  out  1  one-cycle pulse, layer_done observed

Behaviour:
- Reset: state=IDLE; wready, write_weight, layer_start, load_done, run_done, busy = 0; neuron_sel, weight_sel, weight_bus = 0; counters = 0; auto-run flag = 0.
- States: IDLE, LOAD, FLUSH, START, WAIT, DONE.
- IDLE:
  - load_req → LOAD; clear counters; latch run_after.
  - run_req alone → START.
  - load_req and run_req together → load_req wins; run_req is ignored.
- LOAD:
  - wready=1 combinationally, only while in LOAD.
  - Handshake is wvalid&&wready.
  - A word accepted in cycle t drives, in cycle t+1, registered outputs write_weight=1, weight_bus=wdata, and neuron_sel/weight_sel equal to the counter values at t.
  - Counters: weight counter 0..INPUTS-1 increments per accepted word, then wraps to 0 and increments the neuron counter.
  - Accepting word NEURONS*INPUTS-1 (neuron=NEURONS-1, weight=INPUTS-1) → FLUSH; counters wrap to 0.
  - wvalid low stalls with no write. Back-to-back acceptance sustains one write per cycle.
- FLUSH:
  - The final write_weight is visible this cycle. load_done=1 this cycle.
  - Next state: START if the auto-run flag is set, else IDLE.
- START: layer_start=1 for exactly one cycle → WAIT.
- WAIT:
  - layer_done=1 → DONE.
  - layer_done asserted in the same cycle as layer_start is ignored.
- DONE: run_done=1 for one cycle → IDLE.
- write_weight is 0 in every cycle without a preceding accepted word. neuron_sel/weight_sel/weight_bus hold their last values when not writing.
- abort:
  - Highest priority; next state IDLE; counters cleared; wready=0 the same cycle.
  - A word accepted in the cycle before abort still produces its write.
  - Partial loads leave the layer's earlier-written weights in place.
- load_req/run_req outside IDLE are ignored (no queueing).
- Mid-operation reset: all outputs return to reset values asynchronously. The layer shares rst_n.

Decomposition:
- Shared package: state enum (3-bit), and a function computing total words NEURONS*INPUTS.
- One natural sub-module: weight_addr_counter (nested weight/neuron counter with wrap and a last flag, parameterised by INPUTS, NEURONS). The remaining FSM/registers live in layer_sequencer.

Test Plan:
- INPUTS=4, NEURONS=3, load_req with run_after=0, wvalid held high, wdata=k for word k → 12 consecutive writes with (neuron_sel,weight_sel,weight_bus) = (k/4,k%4,k), each one cycle after acceptance. Then load_done at the last write, no layer_start, return to IDLE.
- Same load with wvalid toggling 1,0,1,0 → writes only after valid cycles, order preserved, total exactly 12 writes.
- load_req with run_after=1 → load_done, then layer_start the next cycle. Model layer_done after 7 cycles → run_done one cycle later, busy drops the following cycle.
- run_req in IDLE → layer_start the next cycle, zero writes. A second run_req during WAIT is ignored; only one run_done.
- abort after 5 accepted words → 5 writes then idle. A new load restarts at neuron 0/weight 0.
- Assert rst_n=0 during WAIT → all outputs 0 immediately. After release, state is IDLE and busy=0.
